// File: rtl/rc4_stream_engine.sv
// RC4 stream cipher engine: runtime key length, optional RC4-drop[N], and a
// byte-stream valid/ready interface around a 256x8 dual-port S-box RAM.
module rc4_stream_engine #(
  parameter int K_MAX_BYTES = 16,
  parameter int DROP_N      = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [K_MAX_BYTES*8-1:0]           key,
  input  logic [$clog2(K_MAX_BYTES+1)-1:0]   key_len,
  output logic                               busy,
  output logic                               keyed,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic [7:0]                         out_data,
  input  logic                               out_ready,
  output logic [3:0]                         dbg_state
);

  localparam int KLW = $clog2(K_MAX_BYTES + 1);
  localparam logic [9:0] DROP_LAST = (DROP_N > 0) ? 10'(DROP_N - 1) : 10'd0;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a raised out_valid holds its
  // data until the sink takes it.
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_KSA_RI, S_KSA_RJ, S_KSA_WR, S_KSA_END,
    S_READY, S_PI, S_PJ, S_SW, S_PK, S_OUT
  } state_t;

  state_t                   state;
  logic [7:0]               i, j, si, sj, byte_q;
  logic [K_MAX_BYTES*8-1:0] key_q;
  logic [KLW-1:0]           len_q, kidx, eff_len_in;
  logic [6:0]               init_cnt;
  logic [9:0]               drop_cnt;

  logic [7:0] s_mem [256];
  logic [7:0] a_addr, a_wd, a_rd, b_addr, b_wd;
  logic       a_we, b_we;

  logic [7:0] key_byte, j_ksa;
  logic       go_start, accept, kidx_last;

  assign dbg_state = state;
  assign key_byte  = key_q[{kidx, 3'b000} +: 8];
  assign j_ksa     = j + a_rd + key_byte;
  assign kidx_last = (kidx == len_q - KLW'(1));
  assign go_start  = start && (state == S_IDLE || state == S_READY);
  // A start in READY wins over a byte offered the same cycle, so do not claim it.
  assign in_ready  = (state == S_READY) && !start && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    if (key_len == '0)
      eff_len_in = KLW'(1);
    else if (key_len > KLW'(K_MAX_BYTES))
      eff_len_in = KLW'(K_MAX_BYTES);
    else
      eff_len_in = key_len;
  end

  // S-box RAM: synchronous read on port A, writes on both ports.
  always_ff @(posedge clk) begin
    if (a_we) s_mem[a_addr] <= a_wd;
    if (b_we) s_mem[b_addr] <= b_wd;
    a_rd <= s_mem[a_addr];
  end

  always_comb begin
    a_addr = i;
    a_we   = 1'b0;
    a_wd   = 8'd0;
    b_addr = 8'd0;
    b_we   = 1'b0;
    b_wd   = 8'd0;
    case (state)
      S_INIT: begin
        a_addr = {init_cnt, 1'b0};
        a_we   = 1'b1;
        a_wd   = {init_cnt, 1'b0};
        b_addr = {init_cnt, 1'b1};
        b_we   = 1'b1;
        b_wd   = {init_cnt, 1'b1};
      end
      S_KSA_RI: a_addr = i;
      S_KSA_RJ: a_addr = j_ksa;
      S_PI:     a_addr = i + 8'd1;
      S_PJ:     a_addr = j + a_rd;
      S_PK:     a_addr = si + sj;
      S_KSA_WR, S_SW: begin
        // a_rd holds S[j] here; port B stays quiet when i == j.
        a_addr = i;
        a_we   = 1'b1;
        a_wd   = a_rd;
        b_addr = j;
        b_we   = (i != j);
        b_wd   = si;
      end
      default: a_addr = i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      keyed     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      i         <= 8'd0;
      j         <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      byte_q    <= 8'd0;
      key_q     <= '0;
      len_q     <= KLW'(1);
      kidx      <= '0;
      init_cnt  <= 7'd0;
      drop_cnt  <= 10'd0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (go_start) begin
        state     <= S_INIT;
        busy      <= 1'b1;
        keyed     <= 1'b0;
        out_valid <= 1'b0;
        key_q     <= key;
        len_q     <= eff_len_in;
        i         <= 8'd0;
        j         <= 8'd0;
        kidx      <= '0;
        init_cnt  <= 7'd0;
        drop_cnt  <= 10'd0;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_INIT: begin
            init_cnt <= init_cnt + 7'd1;
            if (init_cnt == 7'd127) state <= S_KSA_RI;
          end
          S_KSA_RI: state <= S_KSA_RJ;
          S_KSA_RJ: begin
            si    <= a_rd;
            j     <= j_ksa;
            state <= S_KSA_WR;
          end
          S_KSA_WR: begin
            i     <= i + 8'd1;
            kidx  <= kidx_last ? '0 : kidx + KLW'(1);
            state <= (i == 8'hFF) ? S_KSA_END : S_KSA_RI;
          end
          S_KSA_END: begin
            // i has already wrapped to 0; PRGA starts with j = 0 as well.
            j <= 8'd0;
            if (DROP_N == 0) begin
              state <= S_READY;
              busy  <= 1'b0;
              keyed <= 1'b1;
            end else begin
              state <= S_PI;
            end
          end
          S_READY: begin
            if (accept) begin
              byte_q <= in_data;
              state  <= S_PI;
            end
          end
          S_PI: begin
            i     <= i + 8'd1;
            state <= S_PJ;
          end
          S_PJ: begin
            si    <= a_rd;
            j     <= j + a_rd;
            state <= S_SW;
          end
          S_SW: begin
            sj    <= a_rd;
            state <= S_PK;
          end
          S_PK: begin
            // keyed low here means these steps are discarded drop iterations.
            if (keyed) begin
              state <= S_OUT;
            end else if (drop_cnt == DROP_LAST) begin
              state <= S_READY;
              busy  <= 1'b0;
              keyed <= 1'b1;
            end else begin
              drop_cnt <= drop_cnt + 10'd1;
              state    <= S_PI;
            end
          end
          S_OUT: begin
            out_data  <= byte_q ^ a_rd;
            out_valid <= 1'b1;
            state     <= S_READY;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Bench for rc4_stream_engine: known-answer vectors plus randomized traffic
// scored against a textbook RC4 model, with a decoupled output monitor.
module tb_rc4_stream_engine;
  localparam int KMAX = 16;
  localparam int KLW  = $clog2(KMAX + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start, in_valid, out_ready;
  logic [KMAX*8-1:0] key;
  logic [KLW-1:0]    key_len;
  logic [7:0]        in_data, out_data;
  logic              busy, keyed, in_ready, out_valid;
  logic [3:0]        dbg_state;

  logic              d1_start, d1_in_valid, d1_out_ready;
  logic [KMAX*8-1:0] d1_key;
  logic [KLW-1:0]    d1_key_len;
  logic [7:0]        d1_in_data, d1_out_data;
  logic              d1_busy, d1_keyed, d1_in_ready, d1_out_valid;
  logic [3:0]        d1_dbg_state;

  rc4_stream_engine #(.K_MAX_BYTES(KMAX), .DROP_N(0)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .key_len(key_len),
    .busy(busy), .keyed(keyed), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  rc4_stream_engine #(.K_MAX_BYTES(KMAX), .DROP_N(1)) dut_drop (
    .clk(clk), .reset(reset), .start(d1_start), .key(d1_key), .key_len(d1_key_len),
    .busy(d1_busy), .keyed(d1_keyed), .in_valid(d1_in_valid), .in_data(d1_in_data),
    .in_ready(d1_in_ready), .out_valid(d1_out_valid), .out_data(d1_out_data),
    .out_ready(d1_out_ready), .dbg_state(d1_dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  logic [7:0] v_plain  [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] v_wiki   [5]  = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] v_secret [14] = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                                8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain RC4 over an array
  logic [7:0] m_s [256];
  int m_i, m_j;

  function automatic int eff_len(input int len);
    if (len == 0) return 1;
    if (len > KMAX) return KMAX;
    return len;
  endfunction

  task automatic model_key(input logic [KMAX*8-1:0] k, input int len);
    int jj;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + m_s[n] + k[8*(n % len) +: 8]) % 256;
      t = m_s[n]; m_s[n] = m_s[jj]; m_s[jj] = t;
    end
    m_i = 0;
    m_j = 0;
  endtask

  task automatic model_ks(output logic [7:0] ks);
    logic [7:0] t;
    m_i = (m_i + 1) % 256;
    m_j = (m_j + m_s[m_i]) % 256;
    t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
    ks = m_s[(m_s[m_i] + m_s[m_j]) % 256];
  endtask

  function automatic logic [KMAX*8-1:0] str_key(input string s);
    logic [KMAX*8-1:0] r;
    r = '0;
    for (int k = 0; k < s.len(); k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  // sink backpressure: 0 always ready, 1 random, 2 hold each byte 20 cycles
  int bp_mode = 0;
  int hold_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!out_valid) begin
            hold_cnt = 0;
            out_ready = 1'b0;
          end else if (hold_cnt < 20) begin
            hold_cnt++;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // scoreboard monitor
  logic held = 1'b0;
  logic [7:0] held_data = 8'd0;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        held = 1'b0;
      end else if (out_valid) begin
        if (held) chk("out_data_stable", out_data, held_data);
        if (!out_ready) begin
          chk("in_ready_blocked", in_ready, 0);
          held = 1'b1;
          held_data = out_data;
        end else begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %0h, expected no output", out_data);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [KMAX*8-1:0] k, input int len);
    int cnt;
    @(negedge clk);
    key = k;
    key_len = KLW'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    model_key(k, eff_len(len));
    cnt = 0;
    while (!keyed && cnt < 3000) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("keyed_latency", cnt, 897);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] vec_exp, input bit use_vec);
    logic [7:0] ks;
    bit acc;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      #4;
      if (in_ready) acc = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept, expected accept within 500 cycles");
    end else begin
      model_ks(ks);
      exp_q.push_back(use_vec ? vec_exp : (b ^ ks));
    end
  endtask

  task automatic send_vec(input string s, input int sel);
    for (int k = 0; k < s.len(); k++) begin
      logic [7:0] e;
      case (sel)
        0: e = v_plain[k];
        1: e = v_wiki[k];
        default: e = v_secret[k];
      endcase
      send_byte(s[k], e, 1'b1);
    end
  endtask

  task automatic send_random(input int count);
    for (int k = 0; k < count; k++) send_byte(8'($urandom_range(0, 255)), 8'd0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_keyed"}, keyed, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before 900us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    logic [KMAX*8-1:0] rk;
    start = 1'b0; in_valid = 1'b0; in_data = 8'd0; key = '0; key_len = '0;
    d1_start = 1'b0; d1_in_valid = 1'b0; d1_in_data = 8'd0; d1_key = '0;
    d1_key_len = '0; d1_out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    reset = 1'b0;

    // RC4-drop[1] instance: latency to keyed and first surviving byte
    @(negedge clk);
    d1_key = str_key("Key");
    d1_key_len = KLW'(3);
    d1_start = 1'b1;
    @(posedge clk);
    #1 d1_start = 1'b0;
    cnt = 0;
    while (!d1_keyed && cnt < 3000) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("drop_keyed_latency", cnt, 901);
    @(negedge clk);
    d1_in_valid = 1'b1;
    d1_in_data = 8'h00;
    #4 chk("drop_in_ready", d1_in_ready, 1);
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
    cnt = 0;
    while (!d1_out_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("accept_to_out_latency", cnt, 5);
    chk("drop_out_data", d1_out_data, 8'h9F);

    do_start(str_key("Key"), 3);
    send_vec("Plaintext", 0);
    drain();

    bp_mode = 2;
    do_start(str_key("Key"), 3);
    send_vec("Plaintext", 0);
    drain();
    bp_mode = 0;

    do_start(str_key("Wiki"), 4);
    send_vec("pedia", 1);
    drain();
    do_start(str_key("Secret"), 6);
    send_vec("Attack at dawn", 2);
    drain();

    bp_mode = 1;
    send_random(24);
    drain();

    // key_len 0 behaves as a one-byte key; upper key bytes are junk
    rk = {$urandom, $urandom, $urandom, $urandom};
    rk[7:0] = 8'h4B;
    do_start(rk, 0);
    send_random(12);
    drain();

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk, KMAX + 5);
    send_random(12);
    drain();
    bp_mode = 0;
    @(negedge clk);

    // reset in the middle of KSA
    @(negedge clk);
    key = str_key("Key");
    key_len = KLW'(3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk_reset_outs("reset_mid_ksa");
    reset = 1'b0;

    // reset while a byte sits in the swap step
    do_start(str_key("Key"), 3);
    send_byte(8'h3C, 8'd0, 1'b0);
    drain();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h55;
    #4 chk("mid_byte_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk_reset_outs("reset_mid_byte");
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("no_out_after_reset", out_valid, 0);

    do_start(str_key("Key"), 3);
    send_vec("Plaintext", 0);
    drain();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
